// File: rtl/uart_pkg.sv
// UART shared definitions: receiver FSM states, data width, default bit timing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Shared by the receiver and the transmitter so both agree on frame shape
// and the default 10 MHz / 115200 baud timing.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 87;  // 10 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running.
//
// Ports:
//   clk   - sampling clock
//   rst_n - synchronous active-low reset; both flops load RST_VAL
//   d     - asynchronous input
//   q     - synchronized output
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_8bit.sv
// UART receiver, 8 data bits, 1 stop bit; optional even parity (macro UART_RX_PARITY_EN).
// Latency: byte visible on rx_data/rx_valid one clk after the stop-bit sample.
// Backpressure: one holding register; a byte completing while it is still full and not being read is dropped with an overrun pulse.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - synchronous active-low reset
//   rx         - asynchronous serial line, idle high
//   rx_ready   - consumer takes rx_data when high with rx_valid
//   rx_data    - received byte (LSB arrives first on the line)
//   rx_valid   - rx_data holds an unconsumed byte
//   frame_err  - 1-cycle pulse: stop bit sampled low (byte discarded)
//   overrun    - 1-cycle pulse: good byte dropped, holding register full
//   parity_err - 1-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN)
//   busy       - high whenever the FSM is not in IDLE
import uart_pkg::*;

module uart_rx_8bit #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

  logic            rx_s;
  rx_state_t       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_cnt, bit_nxt;
  logic [7:0]      shift, shift_nxt;
  logic            stop_sample;
  logic            frame_bad, par_bad, byte_good;
  logic [1:0]      flush;
  logic            armed;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // The synchronizer shows its reset value (1) for two cycles after reset,
  // so a line held low through reset would look like a fresh falling edge.
  // 'armed' only sets once a real high has come through the synchronizer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush <= 2'b00;
      armed <= 1'b0;
    end else begin
      flush <= {flush[0], 1'b1};
      armed <= armed | (flush[1] & rx_s);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_nxt     = bit_cnt;
    shift_nxt   = shift;
    stop_sample = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (armed && !rx_s) begin
          state_nxt = START;
          bit_nxt   = '0;
        end
      end
      START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_s, shift[7:1]};
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt   = '0;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt     = '0;
          stop_sample = 1'b1;
          state_nxt   = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_bit <= 1'b0;
    end else if (state == PARITY && cnt == FULL_LAST) begin
      par_bit <= rx_s;
    end
  end

  // Even parity: data bits plus parity bit must XOR to zero. A low stop
  // bit wins over a parity mismatch.
  assign par_bad = stop_sample & rx_s & (^{shift, par_bit});

  always_ff @(posedge clk) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= par_bad;
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign frame_bad = stop_sample & ~rx_s;
  assign byte_good = stop_sample & rx_s & ~par_bad;

  // A simultaneous read frees the holding register in time for the new
  // byte, so it is loaded and rx_valid simply stays high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      overrun   <= byte_good & rx_valid & ~rx_ready;
      if (byte_good && (!rx_valid || rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_8bit.sv
// Self-checking bench for uart_rx_8bit at CLKS_PER_BIT = 16.
// Latency: n/a (testbench).
// Backpressure: drives rx_ready to exercise both consumption and overrun.
module tb_uart_rx_8bit;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int perr_cnt = 0;
  int take_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
  } vec_t;

  vec_t vecs[6];

  uart_rx_8bit #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Monitor on the falling edge: inputs change just after the rising edge,
  // so rx_valid & rx_ready seen here is what the next rising edge uses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err)  ferr_cnt++;
      if (overrun)    ovr_cnt++;
      if (parity_err) perr_cnt++;
      if (rx_valid && rx_ready) begin
        logic [7:0] e;
        take_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got=%02h expected=none", rx_data);
        end else begin
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            errors++;
            $display("FAIL sb_data got=%02h expected=%02h", rx_data, e);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    return {stop, ^d, d, 1'b0};
`else
    return {1'b0, stop, d, 1'b0};
`endif
  endfunction

  // Drives bits LSB-first, one bit time each; leaves rx at the last bit.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      tick(CPB);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bits(frame_bits(d, stop), NB);
    rx = 1'b1;
  endtask

  task automatic wait_busy_low(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  rx_data,    8'h00);
    check({tag, "_valid"}, rx_valid,   0);
    check({tag, "_ferr"},  frame_err,  0);
    check({tag, "_ovr"},   overrun,    0);
    check({tag, "_perr"},  parity_err, 0);
    check({tag, "_busy"},  busy,       0);
  endtask

  initial begin
    int t0, f0, o0, p0;

    vecs[0] = '{8'hA5, 1'b1};
    vecs[1] = '{8'h00, 1'b1};
    vecs[2] = '{8'hFF, 1'b1};
    vecs[3] = '{8'h55, 1'b0};
    vecs[4] = '{8'h01, 1'b1};
    vecs[5] = '{8'h80, 1'b1};

    // Reset state
    tick(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick(4);

    // Table of frames with the consumer always ready
    for (int v = 0; v < 6; v++) begin
      t0 = take_cnt; f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
      if (vecs[v].stop) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop);
      tick(3 * CPB);
      check($sformatf("vec%0d_take", v), take_cnt - t0, vecs[v].stop ? 1 : 0);
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].stop ? 0 : 1);
      check($sformatf("vec%0d_ovr", v),  ovr_cnt - o0, 0);
      check($sformatf("vec%0d_perr", v), perr_cnt - p0, 0);
      check($sformatf("vec%0d_idle", v), busy, 0);
    end

    // Overrun: consumer stalled across two frames
    rx_ready = 1'b0;
    t0 = take_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    tick(2 * CPB);
    check("ovr_first_valid", rx_valid, 1);
    check("ovr_first_data", rx_data, 8'h3C);
    send_frame(8'h81, 1'b1);
    tick(2 * CPB);
    check("ovr_pulse", ovr_cnt - o0, 1);
    check("ovr_data_held", rx_data, 8'h3C);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_no_take", take_cnt - t0, 0);
    rx_ready = 1'b1;
    tick(2);
    check("ovr_drain_take", take_cnt - t0, 1);
    check("ovr_drain_valid", rx_valid, 0);

    // Break: bad stop bit then line held low for 40 bit times
    t0 = take_cnt; f0 = ferr_cnt;
    send_bits(frame_bits(8'h55, 1'b0), NB);
    tick(20 * CPB);
    check("brk_busy_mid", busy, 1);
    tick(20 * CPB);
    check("brk_busy_end", busy, 1);
    check("brk_ferr", ferr_cnt - f0, 1);
    check("brk_no_take", take_cnt - t0, 0);
    rx = 1'b1;
    wait_busy_low(6, "brk_release");
    tick(2 * CPB);

    // Glitch: 4-cycle low pulse on idle line
    t0 = take_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    check("glitch_busy_seen", busy, 1);
    wait_busy_low(12, "glitch_idle");
    tick(2 * CPB);
    check("glitch_no_take", take_cnt - t0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

`ifdef UART_RX_PARITY_EN
    // Parity: 0x07 has three ones, so the even-parity bit is 1
    t0 = take_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
    rx = 1'b1;
    tick(3 * CPB);
    check("par_bad_perr", perr_cnt - p0, 1);
    check("par_bad_no_take", take_cnt - t0, 0);
    check("par_bad_no_ferr", ferr_cnt - f0, 0);
    exp_q.push_back(8'h07);
    send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 11);
    rx = 1'b1;
    tick(3 * CPB);
    check("par_good_take", take_cnt - t0, 1);
    check("par_good_perr", perr_cnt - p0, 1);
`endif

    // Reset during data bit 4 of 0xF0, line low across reset release
    t0 = take_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;  // bits 0..3 of 0xF0
      tick(CPB);
    end
    rx = 1'b1;    // bit 4 of 0xF0
    tick(CPB / 2);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    rx = 1'b0;
    tick(2);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    tick(3 * CPB);
    check("rst_low_no_start", busy, 0);
    rx = 1'b1;
    tick(2 * CPB);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    tick(3 * CPB);
    check("post_rst_take", take_cnt - t0, 1);
    check("post_rst_no_ferr", ferr_cnt - f0, 0);

    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_8bit.md
UART_RX_8BIT -- requirements
Module: uart_rx_8bit

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, clock cycles per serial bit (10 MHz / 115200 baud); legal range 4..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 rx  input  1  asynchronous serial line, idle high, 8N1 framing (8E1 with parity build).
REQ-005 rx_ready  input  1  consumer accepts rx_data when high together with rx_valid.
REQ-006 rx_data  output  8  received byte, LSB received first.
REQ-007 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 overrun  output  1  one-cycle pulse: completed byte dropped because holding register was full.
REQ-010 parity_err  output  1  one-cycle pulse: parity mismatch (constant 0 without parity build).
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer, both flops reset to 1; all decoding uses the synchronized value.
REQ-013 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-014 IDLE -> START on synchronized rx = 0; bit counter cleared.
REQ-015 START: sample after CLKS_PER_BIT/2 (integer division) cycles; rx = 1 -> IDLE (glitch, no output), rx = 0 -> DATA.
REQ-016 DATA: sample every CLKS_PER_BIT cycles; 8 samples, shifted in LSB-first; after the 8th -> PARITY (parity build) or STOP.
REQ-017 PARITY: one sample CLKS_PER_BIT cycles later; even parity over 8 data bits plus parity bit; mismatch flagged at STOP evaluation.
REQ-018 STOP: sample CLKS_PER_BIT cycles later; rx = 1 -> byte good, IDLE; rx = 0 -> frame_err pulse, byte discarded, BREAK.
REQ-019 BREAK: wait for synchronized rx = 1, then IDLE; no start detection while in BREAK.
REQ-020 Good byte with parity mismatch: parity_err pulse, byte discarded, no rx_valid.
REQ-021 Good byte: rx_data and rx_valid updated on the clock edge after the stop sample (1-cycle latency).
REQ-022 Handshake: rx_valid & rx_ready at an edge clears rx_valid; rx_data holds until next load.
REQ-023 Good byte while rx_valid = 1 and rx_ready = 0: new byte dropped, rx_data unchanged, overrun pulse.
REQ-024 Good byte while rx_valid = 1 and rx_ready = 1 same cycle: new byte loaded, rx_valid stays 1, no overrun.
REQ-025 Sample counter width = $clog2(CLKS_PER_BIT); counter reloads at each sample; no wrap past CLKS_PER_BIT-1.
REQ-026 Error pulses are mutually exclusive within one frame; frame_err takes priority over parity_err and overrun.

Reset
REQ-027 rst_n = 0 at a clock edge: FSM -> IDLE, counters 0, shift register 0, synchronizer flops 1.
REQ-028 Reset values: rx_data 0x00, rx_valid 0, frame_err 0, overrun 0, parity_err 0, busy 0.
REQ-029 Reset mid-frame aborts the frame; no partial byte, no error pulse; rx low at release does not start a frame until rx returns high then falls.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: PARITY state present, frame 11 bits, parity_err live.
REQ-031 Macro UART_RX_PARITY_EN undefined: PARITY state and parity logic absent, frame 10 bits, parity_err tied 0.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum, DATA_BITS = 8, and default CLKS_PER_BIT constant, shared with the transmitter.
REQ-033 Sub-module uart_rx_sync (2-flop synchronizer, reset value parameterized) SHALL be instantiated for rx.

Verification
REQ-034 CLKS_PER_BIT = 16, send 0xA5 8N1, rx_ready = 1 -> rx_valid for one cycle, rx_data = 0xA5, no error pulses.
REQ-035 Send 0x3C then 0x81 with rx_ready = 0 -> rx_data stays 0x3C, one overrun pulse, rx_valid remains 1.
REQ-036 Send 0x55 with stop bit forced low, then hold rx low 40 bit times -> one frame_err pulse, no rx_valid, busy until rx high.
REQ-037 Low pulse of 4 cycles on idle rx -> no rx_valid, FSM back to IDLE, busy deasserts within 12 cycles.
REQ-038 UART_RX_PARITY_EN: send 0x07 with wrong parity bit -> one parity_err pulse, no rx_valid; correct parity -> rx_data = 0x07.
REQ-039 Assert rst_n = 0 during DATA bit 4 of 0xF0 -> all outputs at reset values, next clean frame 0x12 received correctly.
